// File: rtl/message_stream_deframer.sv
// Splits a header-delimited word stream into payload packets with first/last markers.
// It reports malformed headers and stalled packets, then resynchronises on the next header.
module message_stream_deframer #(
  parameter int unsigned WDTH              = 32,
  parameter int unsigned MAX_PACKET_LENGTH = 64,
  parameter int unsigned MSG_LENGTH_WIDTH  = 7,
  parameter int unsigned TIMEOUT           = 1024,
  parameter int unsigned TIMEOUT_WIDTH     = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WDTH-1:0] in_data,
  input  logic            in_nd,
  output logic [WDTH-1:0] out_data,
  output logic            out_nd,
  output logic            out_first,
  output logic            out_last,
  output logic [15:0]     packet_count,
  output logic            error,
  output logic [1:0]      error_code
);

  localparam logic [MSG_LENGTH_WIDTH-1:0] MaxLen     = MSG_LENGTH_WIDTH'(MAX_PACKET_LENGTH);
  localparam logic [MSG_LENGTH_WIDTH-1:0] OneLen     = MSG_LENGTH_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0]    TimeoutVal = TIMEOUT_WIDTH'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StPayload} state_e;

  state_e                      r_state, w_state_d;
  logic [MSG_LENGTH_WIDTH-1:0] r_remaining, w_remaining_d;
  logic                        r_first, w_first_d;
  logic [TIMEOUT_WIDTH-1:0]    r_timer, w_timer_d, w_timer_inc;
  logic [WDTH-1:0]             r_out_data, w_out_data_d;
  logic                        r_out_nd, w_out_nd_d;
  logic                        r_out_first, w_out_first_d;
  logic                        r_out_last, w_out_last_d;
  logic [15:0]                 r_count, w_count_d;
  logic                        r_error, w_error_d;
  logic [1:0]                  r_error_code, w_error_code_d;
  logic [MSG_LENGTH_WIDTH-1:0] w_len;

  assign w_len       = in_data[MSG_LENGTH_WIDTH-1:0];
  assign w_timer_inc = r_timer + TIMEOUT_WIDTH'(1);

  always_comb begin
    w_state_d      = r_state;
    w_remaining_d  = r_remaining;
    w_first_d      = r_first;
    w_timer_d      = r_timer;
    w_out_data_d   = r_out_data;
    w_out_nd_d     = 1'b0;
    w_out_first_d  = 1'b0;
    w_out_last_d   = 1'b0;
    w_count_d      = r_count;
    w_error_d      = 1'b0;
    w_error_code_d = 2'd0;
    unique case (r_state)
      StIdle: begin
        if (in_nd) begin
          if (!in_data[WDTH-1]) begin
            w_error_d      = 1'b1;
            w_error_code_d = 2'd1;
          end else if (w_len == '0) begin
            w_count_d = r_count + 16'd1;
          end else if (w_len > MaxLen) begin
            w_error_d      = 1'b1;
            w_error_code_d = 2'd2;
          end else begin
            w_remaining_d = w_len;
            w_first_d     = 1'b1;
            w_timer_d     = '0;
            w_state_d     = StPayload;
          end
        end
      end
      StPayload: begin
        if (in_nd) begin
          // Payload MSB is plain data here; only IDLE interprets headers.
          w_out_data_d  = in_data;
          w_out_nd_d    = 1'b1;
          w_out_first_d = r_first;
          w_first_d     = 1'b0;
          w_out_last_d  = (r_remaining == OneLen);
          w_remaining_d = r_remaining - OneLen;
          w_timer_d     = '0;
          if (r_remaining == OneLen) begin
            w_count_d = r_count + 16'd1;
            w_state_d = StIdle;
          end
        end else if (TIMEOUT != 0) begin
          w_timer_d = w_timer_inc;
          if (w_timer_inc == TimeoutVal) begin
            w_error_d      = 1'b1;
            w_error_code_d = 2'd3;
            w_timer_d      = '0;
            w_state_d      = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_remaining  <= '0;
      r_first      <= 1'b0;
      r_timer      <= '0;
      r_out_data   <= '0;
      r_out_nd     <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_count      <= '0;
      r_error      <= 1'b0;
      r_error_code <= 2'd0;
    end else begin
      r_state      <= w_state_d;
      r_remaining  <= w_remaining_d;
      r_first      <= w_first_d;
      r_timer      <= w_timer_d;
      r_out_data   <= w_out_data_d;
      r_out_nd     <= w_out_nd_d;
      r_out_first  <= w_out_first_d;
      r_out_last   <= w_out_last_d;
      r_count      <= w_count_d;
      r_error      <= w_error_d;
      r_error_code <= w_error_code_d;
    end
  end

  assign out_data     = r_out_data;
  assign out_nd       = r_out_nd;
  assign out_first    = r_out_first;
  assign out_last     = r_out_last;
  assign packet_count = r_count;
  assign error        = r_error;
  assign error_code   = r_error_code;

endmodule

// File: tb/tb_message_stream_deframer.sv
// Directed bench for message_stream_deframer: good packets, bad headers, timeout, reset.
module tb_message_stream_deframer;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_nd;
  logic [31:0] out_data;
  logic        out_nd;
  logic        out_first;
  logic        out_last;
  logic [15:0] packet_count;
  logic        error;
  logic [1:0]  error_code;

  int n_tests = 0;
  int n_fail  = 0;

  message_stream_deframer #(
    .WDTH              (32),
    .MAX_PACKET_LENGTH (64),
    .MSG_LENGTH_WIDTH  (7),
    .TIMEOUT           (1024),
    .TIMEOUT_WIDTH     (11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_nd        (in_nd),
    .out_data     (out_data),
    .out_nd       (out_nd),
    .out_first    (out_first),
    .out_last     (out_last),
    .packet_count (packet_count),
    .error        (error),
    .error_code   (error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one input cycle, then sample just after the capturing edge.
  task automatic drive(input logic nd, input logic [31:0] d);
    @(negedge clk);
    in_nd   = nd;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  // Checks the registered outputs produced by the word just driven.
  task automatic expect_out(input string tag, input logic nd, input logic [31:0] d,
                            input logic f, input logic l);
    check({tag, ".nd"}, {31'd0, out_nd}, {31'd0, nd});
    if (nd) check({tag, ".data"}, out_data, d);
    check({tag, ".first"}, {31'd0, out_first}, {31'd0, f});
    check({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
    check({tag, ".err"}, {31'd0, error}, 32'd0);
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check({tag, ".err"}, {31'd0, error}, 32'd1);
    check({tag, ".code"}, {30'd0, error_code}, {30'd0, code});
    check({tag, ".nd"}, {31'd0, out_nd}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    in_nd   = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.nd", {31'd0, out_nd}, 32'd0);
    check("rst.err", {31'd0, error}, 32'd0);
    check("rst.code", {30'd0, error_code}, 32'd0);
    check("rst.count", {16'd0, packet_count}, 32'd0);
    check("rst.data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three-word packet, back-to-back
    drive(1'b1, 32'h8000_0003); expect_out("t1.hdr", 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_000A); expect_out("t1.w0", 1'b1, 32'hA, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_000B); expect_out("t1.w1", 1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_000C); expect_out("t1.w2", 1'b1, 32'hC, 1'b0, 1'b1);
    check("t1.count", {16'd0, packet_count}, 32'd1);
    drive(1'b0, 32'h0); expect_out("t1.idle", 1'b0, 32'h0, 1'b0, 1'b0);

    // 2: non-header in IDLE, then single-word packet
    drive(1'b1, 32'h0000_0005); expect_err("t2.nohdr", 2'd1);
    drive(1'b1, 32'h8000_0001); expect_out("t2.hdr", 1'b0, 32'h0, 1'b0, 1'b0);
    check("t2.code0", {30'd0, error_code}, 32'd0);
    drive(1'b1, 32'h0000_0007); expect_out("t2.w0", 1'b1, 32'h7, 1'b1, 1'b1);
    check("t2.count", {16'd0, packet_count}, 32'd2);

    // 3: length 65 rejected, then a good two-word packet
    drive(1'b1, 32'h8000_0041); expect_err("t3.long", 2'd2);
    drive(1'b1, 32'h8000_0002); expect_out("t3.hdr", 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0001); expect_out("t3.w0", 1'b1, 32'h1, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_0002); expect_out("t3.w1", 1'b1, 32'h2, 1'b0, 1'b1);
    check("t3.count", {16'd0, packet_count}, 32'd3);

    // 4: stall mid-packet; error after the 1024th idle cycle
    drive(1'b1, 32'h8000_0002);
    drive(1'b1, 32'h0000_0055); expect_out("t4.w0", 1'b1, 32'h55, 1'b1, 1'b0);
    n = 0;
    while (n < 1100) begin
      drive(1'b0, 32'h0);
      n++;
      if (error || out_nd) break;
    end
    check("t4.cycles", n, 32'd1024);
    expect_err("t4.timeout", 2'd3);
    check("t4.last", {31'd0, out_last}, 32'd0);
    check("t4.count", {16'd0, packet_count}, 32'd3);
    drive(1'b1, 32'h0000_0066); expect_err("t4.idle", 2'd1);

    // 5: zero-length header, then payload word with MSB set
    drive(1'b1, 32'h8000_0000); expect_out("t5.zero", 1'b0, 32'h0, 1'b0, 1'b0);
    check("t5.count0", {16'd0, packet_count}, 32'd4);
    drive(1'b1, 32'h8000_0002);
    drive(1'b1, 32'h8000_0009); expect_out("t5.w0", 1'b1, 32'h8000_0009, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_0003); expect_out("t5.w1", 1'b1, 32'h3, 1'b0, 1'b1);
    check("t5.count", {16'd0, packet_count}, 32'd5);

    // 6: asynchronous reset mid-packet
    drive(1'b1, 32'h8000_0003);
    drive(1'b1, 32'h0000_0011); expect_out("t6.w0", 1'b1, 32'h11, 1'b1, 1'b0);
    @(negedge clk);
    in_nd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.rst.nd", {31'd0, out_nd}, 32'd0);
    check("t6.rst.count", {16'd0, packet_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h8000_0001); expect_out("t6.hdr", 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_000F); expect_out("t6.w0", 1'b1, 32'hF, 1'b1, 1'b1);
    check("t6.count", {16'd0, packet_count}, 32'd1);
    drive(1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
